// File: rtl/la_drsync.sv
// la_drsync: two-flop synchronizer for a single-bit level, cleared by an async active-low reset.
module la_drsync (
    input  logic clk,
    input  logic in,
    input  logic nreset,
    output logic out
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb sync_d = {sync_q[0], in};

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) sync_q <= '0;
        else sync_q <= sync_d;

    assign out = sync_q[1];
endmodule

// File: rtl/la_clkswitch_ctrl.sv
// la_clkswitch_ctrl: 4-phase req/ack controller that drives break-before-make
// selects for a downstream glitch-free clock mux.
module la_clkswitch_ctrl #(
    parameter     PROP   = "DEFAULT",
    parameter int DRAIN  = 16,
    parameter int RSTSEL = 0,
    parameter int SYNC   = 1
) (
    input  logic clk,
    input  logic nreset,
    input  logic req,
    input  logic target,
    output logic ack,
    output logic sel0,
    output logic sel1,
    output logic current,
    output logic busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DROP  = 2'd1;
    localparam logic [1:0] RAISE = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;
    localparam int         CW    = 8;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN - 1);
    localparam logic       RST_CUR = 1'(RSTSEL);

    logic          req_s;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          next_q, next_d;
    logic          cur_q, cur_d;
    logic          sel0_q, sel0_d;
    logic          sel1_q, sel1_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          rdy_q, rdy_d;

    generate
        if (SYNC == 1) begin : g_sync
            la_drsync u_sync (.clk(clk), .in(req), .nreset(nreset), .out(req_s));
        end else begin : g_nosync
            assign req_s = req;
        end
    endgenerate

    // rdy holds off requests on the first edge after reset release
    always_comb begin
        rdy_d   = 1'b1;
        state_d = state_q;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        next_d  = next_q;
        cur_d   = cur_q;
        sel0_d  = sel0_q;
        sel1_d  = sel1_q;
        case (state_q)
            IDLE:
                if (rdy_q && req_s) begin
                    if (target == cur_q) begin
                        state_d = ACK;
                    end else begin
                        state_d = DROP;
                        next_d  = target;
                        cnt_d   = CNT_LOAD;
                        sel0_d  = 1'b0;
                        sel1_d  = 1'b0;
                    end
                end
            DROP:
                if (cnt_q == '0) begin
                    state_d = RAISE;
                    cnt_d   = CNT_LOAD;
                    cur_d   = next_q;
                    sel0_d  = ~next_q;
                    sel1_d  = next_q;
                end
            RAISE:   state_d = (cnt_q == '0) ? ACK : RAISE;
            ACK:     state_d = req_s ? ACK : IDLE;
            default: state_d = IDLE;
        endcase
        ack_d  = (state_d == ACK);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            next_q  <= RST_CUR;
            cur_q   <= RST_CUR;
            sel0_q  <= ~RST_CUR;
            sel1_q  <= RST_CUR;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            next_q  <= next_d;
            cur_q   <= cur_d;
            sel0_q  <= sel0_d;
            sel1_q  <= sel1_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            rdy_q   <= rdy_d;
        end

    assign ack     = ack_q;
    assign sel0    = sel0_q;
    assign sel1    = sel1_q;
    assign current = cur_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_la_clkswitch_ctrl.sv
// tb_la_clkswitch_ctrl: directed vectors for the clock-switch controller, with an
// unsynchronized and a synchronized instance driven from the same stimulus.
module tb_la_clkswitch_ctrl;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic req = 1'b0;
    logic target = 1'b0;
    logic ack, sel0, sel1, current, busy;
    logic ack_s, sel0_s, sel1_s, current_s, busy_s;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    la_clkswitch_ctrl #(.DRAIN(4), .SYNC(0), .RSTSEL(0)) u_dut (
        .clk(clk), .nreset(nreset), .req(req), .target(target),
        .ack(ack), .sel0(sel0), .sel1(sel1), .current(current), .busy(busy)
    );

    la_clkswitch_ctrl #(.DRAIN(4), .SYNC(1), .RSTSEL(0)) u_dut_s (
        .clk(clk), .nreset(nreset), .req(req), .target(target),
        .ack(ack_s), .sel0(sel0_s), .sel1(sel1_s), .current(current_s), .busy(busy_s)
    );

    // {sel0, sel1, current, ack, busy}
    localparam logic [4:0] IDLE0 = 5'b10100 & 5'b10000;

    typedef struct {
        logic       req;
        logic       target;
        logic [4:0] exp;
    } vec_t;

    always @(negedge clk)
        if ((sel0 && sel1) || (sel0_s && sel1_s)) begin
            fails++;
            $display("FAIL sel_overlap: sel0/sel1=%b%b sync sel0/sel1=%b%b, required never both 1",
                     sel0, sel1, sel0_s, sel1_s);
        end

    function automatic logic [4:0] obs();
        return {sel0, sel1, current, ack, busy};
    endfunction

    function automatic logic [4:0] obs_s();
        return {sel0_s, sel1_s, current_s, ack_s, busy_s};
    endfunction

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got {sel0,sel1,cur,ack,busy}=%b, required %b", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        req    = 1'b0;
        target = 1'b0;
        #1;
        chk("reset_held", obs(), IDLE0);
        chk("reset_held_sync", obs_s(), IDLE0);
        tick();
        tick();
        nreset = 1'b1;
        tick();
        chk("reset_released", obs(), IDLE0);
        chk("reset_released_sync", obs_s(), IDLE0);
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 5'b00001};
        tbl[1]  = '{1'b1, 1'b1, 5'b00001};
        tbl[2]  = '{1'b1, 1'b1, 5'b00001};
        tbl[3]  = '{1'b1, 1'b1, 5'b00001};
        tbl[4]  = '{1'b1, 1'b1, 5'b01101};
        tbl[5]  = '{1'b1, 1'b1, 5'b01101};
        tbl[6]  = '{1'b1, 1'b1, 5'b01101};
        tbl[7]  = '{1'b1, 1'b1, 5'b01101};
        tbl[8]  = '{1'b1, 1'b1, 5'b01111};
        tbl[9]  = '{1'b1, 1'b1, 5'b01111};
        tbl[10] = '{1'b0, 1'b1, 5'b01100};
        tbl[11] = '{1'b0, 1'b1, 5'b01100};
        tbl[12] = '{1'b0, 1'b1, 5'b01100};

        // switch to clk1; the synced instance lags by two edges
        do_reset();
        for (int i = 0; i < 13; i++) begin
            req    = tbl[i].req;
            target = tbl[i].target;
            tick();
            chk($sformatf("sw1_E0+%0d", i), obs(), tbl[i].exp);
            chk($sformatf("sw1_sync_E0+%0d", i), obs_s(), (i >= 2) ? tbl[i-2].exp : IDLE0);
        end

        // matching target: immediate ack, selects untouched
        do_reset();
        req    = 1'b1;
        target = 1'b0;
        tick();
        chk("same_E0", obs(), 5'b10011);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("same_E0+%0d", i), obs(), 5'b10011);
        end
        req = 1'b0;
        tick();
        chk("same_release", obs(), 5'b10000);

        // early drop of req and target flip do not abort the switch
        do_reset();
        req    = 1'b1;
        target = 1'b1;
        tick();
        chk("early_E0", obs(), 5'b00001);
        target = 1'b0;
        tick();
        req = 1'b0;
        for (int i = 2; i < 8; i++) begin
            tick();
            chk($sformatf("early_E0+%0d", i), obs(), (i < 4) ? 5'b00001 : 5'b01101);
        end
        tick();
        chk("early_ack_E0+8", obs(), 5'b01111);
        tick();
        chk("early_done_E0+9", obs(), 5'b01100);
        tick();
        chk("early_stays_idle", obs(), 5'b01100);

        // reset mid-switch, then first request honored on the second edge after release
        do_reset();
        req    = 1'b1;
        target = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_E0+5", obs(), 5'b01101);
        nreset = 1'b0;
        #1;
        chk("mid_async_reset", obs(), IDLE0);
        tick();
        nreset = 1'b1;
        tick();
        chk("post_reset_edge1", obs(), IDLE0);
        tick();
        chk("post_reset_edge2", obs(), 5'b00001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
